// File: rtl/reflet_mailbox.sv
// reflet_mailbox: memory-mapped mailbox responder for the reflet CPU bus.
// Holds a TX FIFO (CPU -> outside) and an RX FIFO (outside -> CPU). Each FIFO
// has a valid/ready stream port.
//
// Ports
//   clk, reset          rising-edge clock; synchronous active-low reset
//   enable, addr        chip select and word register index (0..3)
//   data_in, write_en   CPU write data and direction (1 = write)
//   data_out            registered read data; 0 when not selected or on writes
//   tx_data, tx_valid   TX FIFO head stream out
//   tx_ready            consumer handshake
//   rx_data, rx_valid   producer stream in
//   rx_ready            RX FIFO can take a beat this cycle
//   irq                 level, RX FIFO non-empty
//
// Register map
//   0  rd: RX head (0 if empty)    wr: push data_in into TX
//   1  rd: {txovf, rxovf, txfull, rxnempty}   wr: [2] clears rxovf, [3] clears txovf
//   2  rd: RX count                wr: pop RX head
//   3  rd: TX count                wr: [0] flush TX, [1] flush RX
module reflet_mailbox #(
  parameter int unsigned wordsize = 16,
  parameter int unsigned depth    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic [wordsize-1:0] tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [wordsize-1:0] rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic                irq
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthCnt = CW'(depth);

  // State
  logic [wordsize-1:0] tx_mem_q [depth];
  logic [wordsize-1:0] tx_mem_d [depth];
  logic [wordsize-1:0] rx_mem_q [depth];
  logic [wordsize-1:0] rx_mem_d [depth];
  logic [AW-1:0]       tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [AW-1:0]       rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CW-1:0]       tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic                tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic [wordsize-1:0] data_out_q, data_out_d;

  // Bus decode
  logic bus_wr, bus_rd;
  logic tx_push_req, rx_pop_req, stat_wr, ctl_wr;
  logic tx_flush, rx_flush;

  assign bus_wr      = enable & write_en;
  assign bus_rd      = enable & ~write_en;
  assign tx_push_req = bus_wr & (addr == 2'd0);
  assign stat_wr     = bus_wr & (addr == 2'd1);
  assign rx_pop_req  = bus_wr & (addr == 2'd2);
  assign ctl_wr      = bus_wr & (addr == 2'd3);
  assign tx_flush    = ctl_wr & data_in[0];
  assign rx_flush    = ctl_wr & data_in[1];

  // FIFO status
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic tx_ovf_set, rx_ovf_set;

  assign tx_full  = (tx_cnt_q == DepthCnt);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == DepthCnt);
  assign rx_empty = (rx_cnt_q == '0);

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then.
  assign tx_pop     = ~tx_empty & tx_ready;
  assign tx_push    = tx_push_req & (~tx_full | tx_pop);
  assign tx_ovf_set = tx_push_req & tx_full & ~tx_pop & ~tx_flush;

  // rx_ready also rises while full if the CPU pops this cycle, keeping the
  // count steady instead of stalling the producer.
  assign rx_ready   = ~rx_full | rx_pop_req;
  assign rx_push    = rx_valid & rx_ready;
  assign rx_pop     = rx_pop_req & ~rx_empty;
  assign rx_ovf_set = rx_valid & ~rx_ready;

  // Stream-side outputs
  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_empty ? '0 : tx_mem_q[tx_rptr_q];
  assign irq      = ~rx_empty;
  assign data_out = data_out_q;

  // TX FIFO next state
  always_comb begin
    tx_mem_d  = tx_mem_q;
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
    end else begin
      if (tx_push) begin
        tx_mem_d[tx_wptr_q] = data_in;
        tx_wptr_d           = tx_wptr_q + AW'(1);
      end
      if (tx_pop) begin
        tx_rptr_d = tx_rptr_q + AW'(1);
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
        2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
        default: tx_cnt_d = tx_cnt_q;
      endcase
    end
  end

  // RX FIFO next state
  always_comb begin
    rx_mem_d  = rx_mem_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (rx_flush) begin
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
    end else begin
      if (rx_push) begin
        rx_mem_d[rx_wptr_q] = rx_data;
        rx_wptr_d           = rx_wptr_q + AW'(1);
      end
      if (rx_pop) begin
        rx_rptr_d = rx_rptr_q + AW'(1);
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
        2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
        default: rx_cnt_d = rx_cnt_q;
      endcase
    end
  end

  // Overflow flags: a set in the same cycle as a clear wins.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;
    if (stat_wr && data_in[3]) tx_ovf_d = 1'b0;
    if (stat_wr && data_in[2]) rx_ovf_d = 1'b0;
    if (tx_ovf_set)            tx_ovf_d = 1'b1;
    if (rx_ovf_set)            rx_ovf_d = 1'b1;
  end

  // Read mux samples pre-edge state; write cycles return 0.
  always_comb begin
    data_out_d = '0;
    if (bus_rd) begin
      unique case (addr)
        2'd0: data_out_d = rx_empty ? '0 : rx_mem_q[rx_rptr_q];
        2'd1: data_out_d[3:0] = {tx_ovf_q, rx_ovf_q, tx_full, ~rx_empty};
        2'd2: data_out_d[CW-1:0] = rx_cnt_q;
        2'd3: data_out_d[CW-1:0] = tx_cnt_q;
        default: data_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_cnt_q   <= '0;
      tx_ovf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
      data_out_q <= '0;
    end else begin
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovf_q   <= rx_ovf_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage needs no reset: counts gate every read of it.
  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

endmodule
